// File: rtl/fsm_overlay_pkg.sv
// State and fault-code encodings for the PicoRV32 overlay sequencer.
package fsm_overlay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_QUAL   = 3'd1,
    ST_BOOT   = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_HALTED = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TRAP    = 2'd1;
  localparam logic [1:0] FC_WDT     = 2'd2;
  localparam logic [1:0] FC_ILLEGAL = 2'd3;

  function automatic logic state_resetn(input state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_HALTED);
  endfunction

  function automatic logic state_stall(input state_t s);
    return s != ST_RUN;
  endfunction

endpackage

// File: rtl/fsm_wdt.sv
// Run watchdog: counts cycles since the last kick and flags expiry one cycle
// before the counter would reach the limit. A zero limit disables expiry.
module fsm_wdt #(
  parameter int WDT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_kick,
  input  logic [WDT_W-1:0] i_limit,
  output logic             o_expire
);

  logic [WDT_W-1:0] r_cnt;

  assign o_expire = (i_limit != '0) && (r_cnt == i_limit - WDT_W'(1)) && !i_kick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= i_kick ? '0 : r_cnt + WDT_W'(1);
    end
  end

endmodule

// File: rtl/fsm_overlay_seq.sv
// Sequences the PicoRV32 reset/stall controls from masked board events,
// with a run watchdog, trap capture, sticky fault code and resume-from-halt.
//
// state  | meaning
// IDLE   | CPU held in reset, waiting for a start event
// QUAL   | counting consecutive start samples
// BOOT   | reset held low for a fixed number of cycles
// RUN    | CPU running, watchdog active
// DRAIN  | CPU stalled, letting in-flight work settle
// HALTED | CPU stalled out of reset, may resume on start
// FAULT  | CPU in reset, fault_code sticky until cleared
module fsm_overlay_seq
  import fsm_overlay_pkg::*;
#(
  parameter int IN_W         = 8,
  parameter int STATE_W      = 4,
  parameter int QUAL_CYCLES  = 4,
  parameter int BOOT_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int WDT_W        = 16,
  parameter int CNT_W        = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [IN_W-1:0]    i_fsm_input,
  input  logic [IN_W-1:0]    i_start_mask,
  input  logic [IN_W-1:0]    i_stop_mask,
  input  logic               i_cpu_trap,
  input  logic               i_cpu_heartbeat,
  input  logic [WDT_W-1:0]   i_wdt_limit,
  input  logic               i_clear_fault,
  output logic               o_cpu_resetn,
  output logic               o_cpu_stall,
  output logic [STATE_W-1:0] o_fsm_state,
  output logic [1:0]         o_fault_code,
  output logic [CNT_W-1:0]   o_run_count
);

  localparam int QC_W = $clog2(QUAL_CYCLES + 1);
  localparam int BC_W = $clog2(BOOT_CYCLES + 1);
  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_fault_code;
  logic [1:0]       w_code_nxt;
  logic             r_cpu_resetn;
  logic             r_cpu_stall;
  logic [CNT_W-1:0] r_run_count;
  logic [QC_W-1:0]  r_qual_cnt;
  logic [BC_W-1:0]  r_boot_cnt;
  logic [DC_W-1:0]  r_drain_cnt;
  logic             w_start_hit;
  logic             w_stop_hit;
  logic             w_run_entry;
  logic             w_wdt_en;
  logic             w_wdt_expire;

  assign w_start_hit = |(i_fsm_input & i_start_mask);
  assign w_stop_hit  = |(i_fsm_input & i_stop_mask);
  // Watchdog only advances on edges that keep the CPU in RUN.
  assign w_wdt_en    = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);

  fsm_wdt #(
    .WDT_W(WDT_W)
  ) u_wdt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_run_entry),
    .i_en     (w_wdt_en),
    .i_kick   (i_cpu_heartbeat),
    .i_limit  (i_wdt_limit),
    .o_expire (w_wdt_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_fault_code;
    w_run_entry = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_hit) w_state_nxt = ST_QUAL;
      end
      ST_QUAL: begin
        if (!w_start_hit) w_state_nxt = ST_IDLE;
        else if (r_qual_cnt == QC_W'(QUAL_CYCLES - 1)) w_state_nxt = ST_BOOT;
      end
      ST_BOOT: begin
        if (r_boot_cnt == BC_W'(BOOT_CYCLES - 1)) begin
          w_state_nxt = ST_RUN;
          w_run_entry = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_cpu_trap) begin
          w_state_nxt = ST_FAULT;
          w_code_nxt  = FC_TRAP;
        end else if (w_wdt_expire) begin
          w_state_nxt = ST_FAULT;
          w_code_nxt  = FC_WDT;
        end else if (w_stop_hit) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_cpu_trap) begin
          w_state_nxt = ST_FAULT;
          w_code_nxt  = FC_TRAP;
        end else if (r_drain_cnt == DC_W'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (w_start_hit && !w_stop_hit) begin
          w_state_nxt = ST_RUN;
          w_run_entry = 1'b1;
        end
      end
      ST_FAULT: begin
        if (i_clear_fault) begin
          w_state_nxt = ST_IDLE;
          w_code_nxt  = FC_NONE;
        end
      end
      default: begin
        w_state_nxt = ST_FAULT;
        w_code_nxt  = FC_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_fault_code <= FC_NONE;
      r_cpu_resetn <= 1'b0;
      r_cpu_stall  <= 1'b1;
      r_run_count  <= '0;
      r_qual_cnt   <= '0;
      r_boot_cnt   <= '0;
      r_drain_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fault_code <= w_code_nxt;
      r_cpu_resetn <= state_resetn(w_state_nxt);
      r_cpu_stall  <= state_stall(w_state_nxt);
      // Dwell counters restart at zero whenever the state is (re)entered.
      r_qual_cnt   <= (r_state == ST_QUAL && w_state_nxt == ST_QUAL)
                      ? r_qual_cnt + QC_W'(1) : '0;
      r_boot_cnt   <= (r_state == ST_BOOT && w_state_nxt == ST_BOOT)
                      ? r_boot_cnt + BC_W'(1) : '0;
      r_drain_cnt  <= (r_state == ST_DRAIN && w_state_nxt == ST_DRAIN)
                      ? r_drain_cnt + DC_W'(1) : '0;
      if (w_run_entry && r_run_count != '1) r_run_count <= r_run_count + CNT_W'(1);
    end
  end

  assign o_cpu_resetn = r_cpu_resetn;
  assign o_cpu_stall  = r_cpu_stall;
  assign o_fsm_state  = STATE_W'(r_state);
  assign o_fault_code = r_fault_code;
  assign o_run_count  = r_run_count;

endmodule

// File: doc/fsm_overlay_seq.md
Name: fsm_overlay_seq

Overview:
- Parametrised successor to the current FSM overlay.
- Sequences the PicoRV32 through qualified start, reset release, run, drain/halt and fault states, driven by masked external input events.
- Adds a run watchdog, trap handling, sticky fault reporting and a resume-from-halt path.
- Sits between board-level inputs and the CPU's resetn/stall controls; exports its state for debug.

Parameters:
- IN_W, 8, width of fsm_input and both masks
- STATE_W, 4, width of fsm_state output (must be >=3; encoding zero-extended)
- QUAL_CYCLES, 4, consecutive start samples required in QUAL (>=1)
- BOOT_CYCLES, 2, cycles cpu_resetn held low in BOOT (>=1)
- DRAIN_CYCLES, 3, stall cycles in DRAIN before HALTED (>=1)
- WDT_W, 16, watchdog counter/limit width
- CNT_W, 8, width of run_count

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fsm_input  in  IN_W  external event lines
- start_mask  in  IN_W  start_hit = |(fsm_input & start_mask)
- stop_mask  in  IN_W  stop_hit = |(fsm_input & stop_mask)
- cpu_trap  in  1  PicoRV32 trap
- cpu_heartbeat  in  1  single-cycle watchdog kick from software
- wdt_limit  in  WDT_W  watchdog timeout in cycles; 0 disables watchdog
- clear_fault  in  1  leave FAULT
- cpu_resetn  out  1  CPU reset, active low
- cpu_stall  out  1  CPU clock-enable gate / stall
- fsm_state  out  STATE_W  current state code
- fault_code  out  2  0 none, 1 trap, 2 watchdog, 3 illegal state
- run_count  out  CNT_W  number of entries into RUN, saturating

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst overrides every state, including FAULT mid-operation.
- Reset values: state IDLE, cpu_resetn=0, cpu_stall=1, fault_code=0, run_count=0, all internal counters 0.
- All outputs are registered (Moore) and reflect the state held after each edge.
- State codes: IDLE=0, QUAL=1, BOOT=2, RUN=3, DRAIN=4, HALTED=5, FAULT=6.
- Output table:
  - IDLE, QUAL, BOOT, FAULT: cpu_resetn=0, stall=1.
  - RUN: resetn=1, stall=0.
  - DRAIN, HALTED: resetn=1, stall=1.
- IDLE -> QUAL on an edge with start_hit; qual_cnt=0.
- QUAL, on each edge:
  - start_hit and qual_cnt==QUAL_CYCLES-1 -> BOOT.
  - start_hit otherwise -> qual_cnt++.
  - !start_hit -> IDLE.
  - Net effect: BOOT is reached after QUAL_CYCLES+1 consecutive start_hit edges.
- BOOT: stays for exactly BOOT_CYCLES edges, then RUN. On entry to RUN: wdt_cnt=0 and run_count++ (saturates at all-ones).
- RUN, priority trap > watchdog > stop:
  - cpu_trap -> FAULT, code 1.
  - Watchdog expiry -> FAULT, code 2. Expiry is wdt_limit!=0, wdt_cnt==wdt_limit-1 and !cpu_heartbeat.
  - stop_hit -> DRAIN, drain_cnt=0.
  - Otherwise wdt_cnt = heartbeat ? 0 : wdt_cnt+1.
- DRAIN: cpu_trap -> FAULT, code 1; otherwise HALTED after DRAIN_CYCLES edges. Watchdog is frozen.
- HALTED: start_hit && !stop_hit -> RUN (counts as an entry, wdt_cnt cleared); otherwise stay.
- FAULT:
  - fault_code is sticky.
  - clear_fault -> IDLE with fault_code=0.
  - A trap while in FAULT does not change fault_code.
- Any unencoded state value -> FAULT with code 3 on the next edge.
- Simultaneous start_hit and stop_hit: start wins in IDLE/QUAL (stop is ignored there); stop wins in HALTED.
- Mask of all zeros means that event never fires.

Decomposition:
- Package fsm_overlay_pkg holds the state encoding constants and fault code constants.
- One natural sub-module, fsm_wdt: watchdog counter with clear, enable, limit and expire outputs, WDT_W-parametrised.
- Qualification, boot and drain counters stay inline.

Test Plan:
- Reset and qualification: assert rst 2 cycles, then start_mask=8'h01 and fsm_input=8'h01 held -> after reset fsm_state=0, resetn=0, stall=1. State is 1 after edge 1, 2 after edge 5, 3 after edge 7 with resetn=1, stall=0, run_count=1.
- Qualification abort: fsm_input=8'h01 for 3 edges then 0 -> state returns to 0; BOOT never entered.
- Watchdog: wdt_limit=10 in RUN, heartbeat at cycles 5 and 12, then none -> no fault until 10 cycles after the last heartbeat. Then fsm_state=6, fault_code=2, resetn=0. A clear_fault pulse gives state 0 and fault_code 0.
- Stop/resume: stop_mask=8'h80, pulse bit 7 in RUN -> DRAIN for 3 edges then HALTED (stall=1, resetn=1). start_hit then gives RUN with run_count=2. Simultaneous start+stop in HALTED keeps HALTED.
- Trap priority: in RUN assert cpu_trap, stop_hit and watchdog expiry on the same edge -> FAULT with fault_code=1.
- Reset mid-run: rst pulse while in RUN -> next edge IDLE, run_count=0, fault_code=0, resetn=0.
